// File: rtl/obj_loader.sv
// Mesh stream loader: parses the V/F header, range-checks the payload size and
// writes every payload word into the OBJ RAM at consecutive addresses from 0.
module obj_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_a,
  output logic [3:0]        ram_we,
  output logic [DATA_W-1:0] ram_di,
  output logic [31:0]       vertex_count,
  output logic [31:0]       face_count,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  // 3*(V+F) with 32-bit V and F needs 35 bits; one spare keeps the compare unsigned-safe.
  localparam int N_W = 36;

  typedef enum logic [2:0] {IDLE, HDR_V, HDR_F, CHECK, LOAD, FLUSH, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [N_W-1:0]    n_words;
  logic              hs;
  logic              hdr_ok;

  function automatic logic header_ok(input logic [31:0] v, input logic [31:0] f,
                                     input logic [N_W-1:0] n);
    return (v != 32'd0) && (f != 32'd0) && (n <= N_W'(DEPTH));
  endfunction

  assign n_words = N_W'(3) * (N_W'(vertex_count) + N_W'(face_count));
  assign hdr_ok  = header_ok(vertex_count, face_count, n_words);
  assign hs      = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = HDR_V;
      HDR_V: begin
        s_ready = 1'b1;
        if (hs) state_nxt = HDR_F;
      end
      HDR_F: begin
        s_ready = 1'b1;
        if (hs) state_nxt = CHECK;
      end
      CHECK: state_nxt = hdr_ok ? LOAD : ERR;
      LOAD: begin
        s_ready = 1'b1;
        if (hs && (cnt == last_addr)) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = IDLE;
      ERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered RAM port, header capture and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en       <= 1'b0;
      ram_a        <= '0;
      ram_we       <= 4'h0;
      ram_di       <= '0;
      vertex_count <= 32'd0;
      face_count   <= 32'd0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      cnt          <= '0;
      last_addr    <= '0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      load_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy         <= 1'b1;
          load_err     <= 1'b0;
          vertex_count <= 32'd0;
          face_count   <= 32'd0;
          cnt          <= '0;
        end
        HDR_V: if (hs) vertex_count <= 32'(s_data);
        HDR_F: if (hs) face_count <= 32'(s_data);
        CHECK: last_addr <= ADDR_W'(n_words - N_W'(1));
        LOAD: if (hs) begin
          ram_en <= 1'b1;
          ram_we <= 4'hF;
          ram_a  <= cnt;
          ram_di <= s_data;
          cnt    <= cnt + ADDR_W'(1);
        end
        FLUSH: begin
          load_done <= 1'b1;
          busy      <= 1'b0;
        end
        ERR: begin
          load_err <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
